// File: rtl/led_frame_ctrl.sv
// rtl/led_frame_ctrl.sv - 4x8 LED matrix controller: double-buffered frame store,
// round-robin write arbiter, blanked column scan with 4-bit PWM.
module led_frame_ctrl #(
  parameter int DWELL_LOG2 = 10,
  parameter int BLANK      = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req0_i,
  input  logic [1:0] addr0_i,
  input  logic [7:0] data0_i,
  input  logic       req1_i,
  input  logic [1:0] addr1_i,
  input  logic [7:0] data1_i,
  output logic       gnt0_o,
  output logic       gnt1_o,
  input  logic       swap_req_i,
  output logic       swap_done_o,
  input  logic [3:0] brightness_i,
  output logic [7:0] leds_o,
  output logic [3:0] lcol_o,
  output logic       frame_start_o
);
  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [BW-1:0]         BLANK_MAX = BW'(BLANK - 1);
  localparam logic [DWELL_LOG2-1:0] ON_MAX    = {DWELL_LOG2{1'b1}};

  typedef enum logic {S_BLANK, S_ON} state_e;

  state_e                state_q, state_d;
  logic [1:0]            col_q, col_d;
  logic [BW-1:0]         blank_cnt_q, blank_cnt_d;
  logic [DWELL_LOG2-1:0] on_cnt_q, on_cnt_d;
  logic [3:0]            bright_q, bright_d;
  logic [7:0]            front_q [4];
  logic [7:0]            back_q  [4];
  logic                  pending_q, ptr_q;
  logic [7:0]            leds_q, leds_d;
  logic [3:0]            lcol_q, lcol_d;
  logic                  swap_done_q, frame_start_q;
  logic                  frame_end, commit;

  // ptr_q = 1 means requester 1 has priority on the next contested cycle
  assign gnt0_o = ~rst_i & req0_i & (~req1_i | ~ptr_q);
  assign gnt1_o = ~rst_i & req1_i & (~req0_i |  ptr_q);
  assign commit = frame_end & (pending_q | swap_req_i);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    blank_cnt_d = blank_cnt_q;
    on_cnt_d    = on_cnt_q;
    bright_d    = bright_q;
    frame_end   = 1'b0;
    case (state_q)
      S_BLANK: begin
        if (blank_cnt_q == BLANK_MAX) begin
          state_d     = S_ON;
          blank_cnt_d = '0;
          on_cnt_d    = '0;
          bright_d    = brightness_i;
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
      S_ON: begin
        if (on_cnt_q == ON_MAX) begin
          state_d   = S_BLANK;
          on_cnt_d  = '0;
          col_d     = col_q + 2'd1;
          frame_end = (col_q == 2'd3);
        end else begin
          on_cnt_d = on_cnt_q + 1'b1;
        end
      end
      default: state_d = S_BLANK;
    endcase

    // Pins are registered from next-state so they line up with the scan state
    lcol_d = 4'hF;
    leds_d = '0;
    if (state_d == S_ON) begin
      lcol_d = ~(4'b0001 << col_d);
      if (on_cnt_d[3:0] < bright_d) leds_d = front_q[col_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_BLANK;
      col_q         <= '0;
      blank_cnt_q   <= '0;
      on_cnt_q      <= '0;
      bright_q      <= '0;
      pending_q     <= 1'b0;
      ptr_q         <= 1'b0;
      leds_q        <= '0;
      lcol_q        <= 4'hF;
      swap_done_q   <= 1'b0;
      frame_start_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        front_q[i] <= '0;
        back_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      blank_cnt_q   <= blank_cnt_d;
      on_cnt_q      <= on_cnt_d;
      bright_q      <= bright_d;
      leds_q        <= leds_d;
      lcol_q        <= lcol_d;
      swap_done_q   <= commit;
      frame_start_q <= frame_end;
      pending_q     <= frame_end ? 1'b0 : (pending_q | swap_req_i);
      // The commit copies the pre-edge back buffer; a same-edge write stays in back only
      if (commit) begin
        for (int i = 0; i < 4; i++) front_q[i] <= back_q[i];
      end
      if (gnt0_o) begin
        back_q[addr0_i] <= data0_i;
        ptr_q           <= 1'b1;
      end else if (gnt1_o) begin
        back_q[addr1_i] <= data1_i;
        ptr_q           <= 1'b0;
      end
    end
  end

  assign leds_o        = leds_q;
  assign lcol_o        = lcol_q;
  assign swap_done_o   = swap_done_q;
  assign frame_start_o = frame_start_q;
endmodule

// File: doc/led_frame_ctrl.md
# led_frame_ctrl

Display controller for the 4-column × 8-row LED matrix. It owns a double-buffered 4×8 frame store and shares the back buffer between two write requesters through a round-robin arbiter. It commits frames to the displayed buffer only at frame boundaries, and it sequences the column scan with inter-column blanking and 4-bit PWM brightness. It drives the matrix pins directly; the column outputs are active-low.

## Interface
- DWELL_LOG2, 10: log2 of ON cycles per column. DWELL = 2^DWELL_LOG2. Must be ≥ 4.
- BLANK, 16: blanking cycles before each column. Must be ≥ 1.

- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  reset, synchronous, active-high
- req0 / req1  in  1  write request from requester 0 / 1
- addr0 / addr1  in  2  target column of the back buffer
- data0 / data1  in  8  row data; bit i = row i; 1 = lit
- gnt0 / gnt1  out  1  combinational grant; the write lands on this clock edge
- swap_req  in  1  request to commit the back buffer to the front buffer
- swap_done  out  1  registered 1-cycle pulse: the commit has occurred
- brightness  in  4  global duty; 0 = dark, 15 = 15/16 on
- leds  out  8  row drive, registered, active-high
- lcol  out  4  column select, registered, active-low; only one bit is low at a time
- frame_start  out  1  registered 1-cycle pulse at each frame boundary

## Operation
- **Buffers:** front[0..3] and back[0..3], each 8 bits. Writes go only to back. Display reads only front.
- **Arbiter:**
  - gnt is asserted only when the matching req is high.
  - With a single requester, that requester is granted.
  - When both request, the grant goes to the requester not granted most recently.
  - Pointer reset value favours requester 0.
  - A grant writes back[addr] <= data at that edge. One write per cycle at most.
  - Both gnt outputs are 0 while rst is high.
- **Scan FSM:** state ∈ {BLANK, ON}, with col ∈ 0..3.
  - BLANK lasts BLANK cycles: lcol = 4'b1111, leds = 0. Then the FSM goes to ON with the same col.
  - ON lasts DWELL cycles: lcol has bit col low (col0 = 1110, col1 = 1101, col2 = 1011, col3 = 0111).
  - In ON, leds = front[col] when on_cnt[3:0] < bright_q, otherwise 0.
  - bright_q latches brightness on entry to ON and is held for the whole column.
  - After ON, the FSM goes to BLANK with col+1 mod 4.
  - Frame period = 4·(BLANK+DWELL) cycles.
- **Swap:**
  - swap_req sets a pending flag. Repeat requests while pending are absorbed.
  - The commit happens at the edge that ends col3 ON: front <= back (all 32 bits), pending clears.
  - A swap_req sampled on that same edge is honoured at that boundary.
  - A write granted on the commit edge updates back only. It is not in the committed frame.
- **frame_start:** pulses in the first cycle of col0 BLANK entered from col3 ON. It does not pulse after reset.
- **swap_done:** pulses in the same cycle as frame_start, only when a commit occurred.

## Timing
- **Reset values** (at the edge where rst = 1, and in every following rst-high cycle):
  - state = BLANK, col = 0, counters = 0.
  - front = back = 0, pending = 0, arbiter pointer favours requester 0, bright_q = 0.
  - Outputs: leds = 0, lcol = 4'b1111, swap_done = 0, frame_start = 0.
- **After reset release:** the first cycle is cycle 0 of col0 BLANK.
- **Output latency:** leds and lcol are registered and show the state of the current cycle. A front update is visible from the first ON cycle after the commit.
- **Glitch-free column change:** lcol never moves directly from one low bit to another. At least BLANK all-high cycles separate them.
- **Write-to-display latency:** write, then swap_req, then next frame boundary, then BLANK cycles, then visible.
- **Reset mid-frame:** abandons the scan, clears both buffers and pending, and drops any grant in that cycle.
- **Counter wrap:** on_cnt counts 0..DWELL-1 and blank_cnt counts 0..BLANK-1. Neither overflows its width.

## Test plan
All scenarios use DWELL_LOG2=4, BLANK=2; frame = 72 cycles.
- **Reset / first frame:** hold rst for 3 cycles, release. Required:
  - lcol = 1111 for 2 cycles, then 1110 for 16 cycles.
  - leds = 0 throughout (buffers clear).
  - frame_start first pulses at cycle 72.
- **Arbitration:** req0 and req1 both high continuously, with distinct data. Required:
  - Grants alternate 0,1,0,1… starting with 0.
  - Never both granted.
  - back contents match the last granted writes.
- **Swap boundary:**
  - Write back[2] = 8'hA5, assert swap_req during col1 ON.
  - Required: front unchanged until the col3→col0 edge.
  - Required: swap_done and frame_start pulse together.
  - Required: col2 ON shows 8'hA5 from the next frame.
  - Repeat with swap_req exactly on the boundary edge; it must commit at that boundary.
- **Write on commit edge:**
  - Grant a write of 8'hFF to col0 on the commit edge.
  - Required: front[0] keeps its old value.
  - Required: the write appears after the following swap.
- **PWM:**
  - front[1] = 8'hFF, brightness = 4.
  - Required: leds = FF in exactly 4 of 16 ON cycles of col1.
  - brightness changed mid-column takes effect only in the next column.
  - brightness = 0 gives all dark.
- **Reset mid-operation:**
  - Assert rst during col2 ON with swap pending.
  - Required: lcol = 1111 and leds = 0 on the next cycle.
  - Required: no swap_done, and all buffers read zero afterwards.
